// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing a single-port 256xDW RAM and a small
// memory-mapped I/O block (LED register, switch port) between CPU and loader.
module mem_arbiter #(
  parameter int DW = 16,
  parameter int AW = 9,
  parameter logic [AW-1:0] LED_ADDR = 9'h100,
  parameter logic [AW-1:0] SW_ADDR  = 9'h140
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    cmd0,
  input  logic [1:0]    cmd1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic [AW-2:0] ram_addr,
  output logic          ram_write,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  input  logic [7:0]    sw,
  output logic [7:0]    led
);

  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  typedef enum logic [1:0] {IDLE, ISSUE, RWAIT, DONE} state_t;

  state_t        state_reg;
  logic          gnt_reg;
  logic          last_gnt_reg;
  logic          write_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_reg;
  logic [1:0]    ack_reg;
  logic          ram_write_reg;
  logic [7:0]    led_reg;

  logic [1:0]    cmd_v [2];
  logic [1:0]    pending;
  logic          win;
  logic [1:0]    win_cmd;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;
  logic [1:0]    gnt_ack;

  assign cmd_v[0] = cmd0;
  assign cmd_v[1] = cmd1;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_pend
      assign pending[gi] = (cmd_v[gi] == MREAD) || (cmd_v[gi] == MWRITE);
    end
  endgenerate

  // On a tie the port that did not win last time gets the grant.
  always_comb begin
    win = 1'b0;
    if (pending[0] && pending[1])
      win = ~last_gnt_reg;
    else if (pending[1])
      win = 1'b1;
  end

  assign win_cmd   = win ? cmd1   : cmd0;
  assign win_addr  = win ? addr1  : addr0;
  assign win_wdata = win ? wdata1 : wdata0;
  assign gnt_ack   = gnt_reg ? 2'b10 : 2'b01;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      gnt_reg       <= 1'b0;
      last_gnt_reg  <= 1'b1;
      write_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rdata_reg     <= '0;
      ack_reg       <= 2'b00;
      ram_write_reg <= 1'b0;
      led_reg       <= 8'h00;
    end else begin
      ack_reg       <= 2'b00;
      ram_write_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (|pending) begin
            gnt_reg       <= win;
            last_gnt_reg  <= win;
            write_q       <= (win_cmd == MWRITE);
            addr_q        <= win_addr;
            wdata_q       <= win_wdata;
            ram_write_reg <= (win_cmd == MWRITE) && !win_addr[AW-1];
            state_reg     <= ISSUE;
          end
        end
        ISSUE: begin
          if (!addr_q[AW-1]) begin
            if (write_q) begin
              ack_reg   <= gnt_ack;
              state_reg <= DONE;
            end else begin
              state_reg <= RWAIT;
            end
          end else begin
            // Unmapped I/O: writes vanish, reads return zero.
            if (write_q) begin
              if (addr_q == LED_ADDR)
                led_reg <= wdata_q[7:0];
            end else begin
              rdata_reg <= (addr_q == SW_ADDR) ? {{(DW-8){1'b0}}, sw} : '0;
            end
            ack_reg   <= gnt_ack;
            state_reg <= DONE;
          end
        end
        RWAIT: begin
          rdata_reg <= ram_dout;
          ack_reg   <= gnt_ack;
          state_reg <= DONE;
        end
        DONE: state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Reset gates the write strobe so an interrupted write never lands in the RAM.
  assign ram_write = ram_write_reg & ~reset;
  assign ram_addr  = addr_q[AW-2:0];
  assign ram_din   = wdata_q;
  assign rdata     = rdata_reg;
  assign ack0      = ack_reg[0];
  assign ack1      = ack_reg[1];
  assign busy      = (state_reg != IDLE);
  assign led       = led_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios plus randomized traffic,
// expected acks come from a transaction-level model of the memory map.
module tb_mem_arbiter;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  cmd0, cmd1;
  logic [8:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        ack0, ack1;
  logic [15:0] rdata;
  logic        busy;
  logic [7:0]  ram_addr;
  logic        ram_write;
  logic [15:0] ram_din;
  logic [15:0] ram_dout;
  logic [7:0]  sw;
  logic [7:0]  led;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .cmd0(cmd0), .cmd1(cmd1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1),
    .rdata(rdata), .busy(busy),
    .ram_addr(ram_addr), .ram_write(ram_write), .ram_din(ram_din),
    .ram_dout(ram_dout), .sw(sw), .led(led)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(input int i);
    return 16'(i * 16'h0101) ^ 16'h5A5A;
  endfunction

  // Synchronous single-port RAM with one-cycle read latency.
  logic [15:0] ram [256];
  logic        ram_init;
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
    end else begin
      if (ram_write) ram[ram_addr] <= ram_din;
      ram_dout <= ram[ram_addr];
    end
  end

  typedef struct {
    bit          port;
    logic [15:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          exp_ramw = 0;
  int          act_ramw = 0;

  logic [15:0] ref_mem [256];
  logic [7:0]  ref_led;
  logic [15:0] ref_rd;
  bit          ref_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ref_led  = 8'h00;
    ref_rd   = 16'h0000;
    ref_last = 1'b1;
  endtask

  // Applies one transaction to the memory map, queues the expected ack and
  // returns its latency in cycles from the sampling edge.
  function automatic int model_txn(input bit p, input logic [1:0] c,
                                   input logic [8:0] a, input logic [15:0] d);
    exp_t e;
    int   lat;
    lat = 2;
    if (c == MWRITE) begin
      if (!a[8]) begin
        ref_mem[a[7:0]] = d;
        exp_ramw++;
      end else if (a == 9'h100) begin
        ref_led = d[7:0];
      end
    end else begin
      if (!a[8]) begin
        ref_rd = ref_mem[a[7:0]];
        lat = 3;
      end else if (a == 9'h140) begin
        ref_rd = {8'h00, sw};
      end else begin
        ref_rd = 16'h0000;
      end
    end
    ref_last = p;
    e.port = p;
    e.data = ref_rd;
    exp_q.push_back(e);
    return lat;
  endfunction

  // Monitor: pops the scoreboard on every ack.
  always @(negedge clk) begin
    if (!reset && !ram_init) begin
      exp_t e;
      if (ram_write) act_ramw++;
      if (ack0 && ack1) check("dual_ack", {ack1, ack0}, 2'b01);
      if (ack0 || ack1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ack", {ack1, ack0}, 2'b00);
        end else begin
          e = exp_q.pop_front();
          $display("txn port=%0d rdata=%h expected_port=%0d expected_rdata=%h",
                   ack1, rdata, e.port, e.data);
          check("ack_port", {31'd0, ack1}, {31'd0, e.port});
          check("rdata", {16'd0, rdata}, {16'd0, e.data});
        end
      end
    end
  end

  task automatic run_port(input bit p, input logic [1:0] c, input logic [8:0] a,
                          input logic [15:0] d, input int exp_lat);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    if (p) begin cmd1 = c; addr1 = a; wdata1 = d; end
    else   begin cmd0 = c; addr0 = a; wdata0 = d; end
    while (!got && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if ((p ? ack1 : ack0) === 1'b1) got = 1'b1;
    end
    if (p) cmd1 = MNONE; else cmd0 = MNONE;
    check("ack_seen", {31'd0, got}, 32'd1);
    if (got && exp_lat > 0) check("latency", n, exp_lat);
  endtask

  task automatic single(input bit p, input logic [1:0] c, input logic [8:0] a,
                        input logic [15:0] d);
    int lat;
    lat = model_txn(p, c, a, d);
    run_port(p, c, a, d, lat);
    @(posedge clk);
    #1;
  endtask

  task automatic dual(input logic [1:0] c0, input logic [8:0] a0, input logic [15:0] d0,
                      input logic [1:0] c1, input logic [8:0] a1, input logic [15:0] d1);
    bit w;
    int l0, l1;
    w = ~ref_last;
    if (w == 1'b0) begin
      l0 = model_txn(1'b0, c0, a0, d0);
      l1 = model_txn(1'b1, c1, a1, d1);
      l1 = 0;
    end else begin
      l1 = model_txn(1'b1, c1, a1, d1);
      l0 = model_txn(1'b0, c0, a0, d0);
      l0 = 0;
    end
    fork
      run_port(1'b0, c0, a0, d0, l0);
      run_port(1'b1, c1, a1, d1, l1);
    join
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] rand_addr();
    int r;
    r = $urandom_range(0, 7);
    case (r)
      0: return 9'h100;
      1: return 9'h140;
      2: return {1'b1, 8'($urandom)};
      default: return {1'b0, 8'($urandom_range(0, 31))};
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] c0, c1;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    model_reset();
    reset = 1'b1; ram_init = 1'b1;
    cmd0 = MNONE; cmd1 = MNONE; addr0 = '0; addr1 = '0;
    wdata0 = '0; wdata1 = '0; sw = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    ram_init = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_acks", {ack1, ack0}, 0);
    check("rst_rdata", rdata, 0);
    check("rst_led", led, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_din", ram_din, 0);
    check("rst_ram_write", ram_write, 0);
    reset = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      check("idle_busy", busy, 0);
      check("idle_acks", {ack1, ack0}, 0);
      check("idle_led", led, 0);
    end

    // Simultaneous writes then reads: alternation P0, P1, P0, P1.
    dual(MWRITE, 9'h010, 16'h1111, MWRITE, 9'h011, 16'h2222);
    dual(MREAD, 9'h010, 16'h0000, MREAD, 9'h011, 16'h0000);

    // Single write then read-back with latency checks; P1 parks on 2'b11.
    cmd1 = 2'b11;
    single(1'b0, MWRITE, 9'h005, 16'hBEEF);
    single(1'b0, MREAD, 9'h005, 16'h0000);
    cmd1 = MNONE;

    // LED and switch I/O.
    single(1'b1, MWRITE, 9'h100, 16'h00A5);
    check("led_a5", led, ref_led);
    sw = 8'h3C;
    single(1'b0, MREAD, 9'h140, 16'h0000);

    // Unmapped I/O address.
    single(1'b0, MREAD, 9'h1FF, 16'h0000);
    single(1'b1, MWRITE, 9'h1FF, 16'hFFFF);
    check("led_unchanged", led, ref_led);

    // Reset during RWAIT of a read.
    cmd0 = MREAD; addr0 = 9'h020;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1; cmd0 = MNONE;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    check("rwait_rst_busy", busy, 0);
    check("rwait_rst_rdata", rdata, 0);

    // Reset during ISSUE of a RAM write: the write must not land.
    cmd0 = MWRITE; addr0 = 9'h020; wdata0 = 16'hDEAD;
    @(posedge clk); #1;
    reset = 1'b1; cmd0 = MNONE;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    check("issue_rst_busy", busy, 0);
    check("issue_rst_led", led, 0);
    single(1'b0, MREAD, 9'h020, 16'h0000);

    // Randomized traffic.
    for (int t = 0; t < 150; t++) begin
      sw = 8'($urandom);
      c0 = $urandom_range(0, 1) ? MWRITE : MREAD;
      c1 = $urandom_range(0, 1) ? MWRITE : MREAD;
      case ($urandom_range(0, 2))
        0: single(1'b0, c0, rand_addr(), 16'($urandom));
        1: single(1'b1, c1, rand_addr(), 16'($urandom));
        default: dual(c0, rand_addr(), 16'($urandom), c1, rand_addr(), 16'($urandom));
      endcase
    end

    repeat (5) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 0);
    check("ram_write_count", act_ramw, exp_ramw);
    check("final_led", led, ref_led);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
